// File: rtl/trace_tx.sv
// Writeback trace capture with a first-word-fall-through record FIFO.
// Optional drop_count output is enabled by defining TRACE_DROP_COUNT_EN.
module trace_tx #(
    parameter int unsigned DEPTH   = 8,
    parameter logic [63:0] STOP_PC = 64'h5C
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        trace_en,
    input  logic [63:0] currentpc,
    input  logic [63:0] MemtoRegOut,
    input  logic        trace_ready,
    output logic        trace_valid,
    output logic [63:0] trace_pc,
    output logic [63:0] trace_data,
    output logic [15:0] trace_seq,
    output logic        overflow,
    output logic        done
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [15:0] drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [15:0]   seq;
    logic [63:0]   mem_pc   [DEPTH];
    logic [63:0]   mem_data [DEPTH];
    logic [15:0]   mem_seq  [DEPTH];

    logic capture;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = !empty && trace_ready;
    // A pop on the same edge frees the slot the push needs.
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    always_ff @(posedge CLK) begin
        if (!resetl) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (trace_en) state_nx = RUN;
            RUN: begin
                if (!trace_en)                 state_nx = IDLE;
                else if (currentpc >= STOP_PC) state_nx = DRAIN;
            end
            DRAIN: if (empty || (count == (AW+1)'(1) && pop)) state_nx = DONE;
            DONE:  state_nx = DONE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        done    = 1'b0;
        if (state == RUN && trace_en) capture = 1'b1;
        if (state == DONE)            done    = 1'b1;
        trace_valid = !empty;
        trace_pc    = empty ? '0 : mem_pc[rptr];
        trace_data  = empty ? '0 : mem_data[rptr];
        trace_seq   = empty ? '0 : mem_seq[rptr];
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_pc[wptr]   <= currentpc;
            mem_data[wptr] <= MemtoRegOut;
            mem_seq[wptr]  <= seq;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Dropped records still consume a number so gaps are visible.
            if (capture) seq      <= seq + 16'd1;
            if (drop)    overflow <= 1'b1;
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    always_ff @(posedge CLK) begin
        if (!resetl)
            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end
`endif

endmodule
